// File: rtl/presub_pkg.sv
// Shared definitions for the pre-subtracted product recovery divider.
package presub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PRESUB_WIDTH = 10;

endpackage

// File: rtl/presub_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare, subtract if it fits.
module presub_div_step #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] div_ext;
  logic [WIDTH+1:0] result;

  // Combinational shift/compare/subtract for a single quotient bit
  always_comb begin
    shifted = {rem_in, bit_in};
    div_ext = {2'b00, div};
    q_bit   = (shifted >= div_ext);
    if (q_bit) begin
      result = shifted - div_ext;
    end else begin
      result = shifted;
    end
    rem_out = (WIDTH+1)'(result);
  end

endmodule

// File: rtl/presub_recover_unsigned.sv
// Divides a product by its divisor bit-serially and re-adds the subtrahend to recover d.
module presub_recover_unsigned
  import presub_pkg::*;
#(
  parameter int WIDTH = PRESUB_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] p,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] q,
  output logic [WIDTH-1:0]   r,
  output logic [WIDTH-1:0]   d,
  output logic               div_by_zero
);

  localparam int CW = $clog2(2*WIDTH) + 1;

  state_t             state;
  state_t             state_next;
  logic [2*WIDTH-1:0] work;
  logic [2*WIDTH-1:0] work_next;
  logic [WIDTH:0]     rem;
  logic [WIDTH:0]     step_rem;
  logic               step_bit;
  logic [WIDTH-1:0]   a_hold;
  logic [WIDTH-1:0]   b_hold;
  logic [CW-1:0]      cnt;
  logic               accept;
  logic               last_iter;

  // work holds the dividend on entry and accumulates quotient bits from the LSB side
  presub_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .bit_in  (work[2*WIDTH-1]),
    .div     (b_hold),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  assign work_next = {work[2*WIDTH-2:0], step_bit};
  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt == CW'(2*WIDTH-1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (b == WIDTH'(0)) ? DONE : RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; in_ready is also masked by reset
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = !rst;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      work        <= '0;
      rem         <= '0;
      a_hold      <= '0;
      b_hold      <= '0;
      cnt         <= '0;
      q           <= '0;
      r           <= '0;
      d           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work   <= p;
            rem    <= '0;
            a_hold <= a;
            b_hold <= b;
            cnt    <= '0;
            if (b == WIDTH'(0)) begin
              q           <= {(2*WIDTH){1'b1}};
              r           <= p[WIDTH-1:0];
              d           <= a - WIDTH'(1);
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          work <= work_next;
          rem  <= step_rem;
          cnt  <= cnt + CW'(1);
          if (last_iter) begin
            q           <= work_next;
            r           <= step_rem[WIDTH-1:0];
            d           <= a_hold + work_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_presub_recover_unsigned.sv
// Self-checking bench: directed cases plus randomized requests against an arithmetic model.
module tb_presub_recover_unsigned;

  localparam int W = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] p;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] q;
  logic [W-1:0]   r;
  logic [W-1:0]   d;
  logic           div_by_zero;

  int checks   = 0;
  int failures = 0;

  presub_recover_unsigned #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .p           (p),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q           (q),
    .r           (r),
    .d           (d),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait for its result; leaves the result pending in DONE.
  task automatic run_req(input logic [2*W-1:0] tp, input logic [W-1:0] ta,
                         input logic [W-1:0] tb, input bit noisy);
    longint unsigned lp, lb, mask;
    logic [2*W-1:0]  eq;
    logic [W-1:0]    er, ed;
    logic            edz;
    int              lat, exp_lat;
    lp   = 64'(tp);
    lb   = 64'(tb);
    mask = (64'd1 << W) - 64'd1;
    if (lb == 64'd0) begin
      eq      = {(2*W){1'b1}};
      er      = W'(lp & mask);
      ed      = W'((64'(ta) + mask) & mask);
      edz     = 1'b1;
      exp_lat = 1;
    end else begin
      eq      = (2*W)'(lp / lb);
      er      = W'(lp % lb);
      ed      = W'((64'(ta) + (lp / lb)) & mask);
      edz     = 1'b0;
      exp_lat = 2*W + 1;
    end
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    check("ready_before_req", 64'(in_ready), 64'd1);
    p        = tp;
    a        = ta;
    b        = tb;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      in_valid  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      p         = (2*W)'($urandom);
      a         = W'($urandom);
      b         = W'($urandom);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("latency", 64'(lat), 64'(exp_lat));
    check("out_valid", 64'(out_valid), 64'd1);
    check("q", 64'(q), 64'(eq));
    check("r", 64'(r), 64'(er));
    check("d", 64'(d), 64'(ed));
    check("div_by_zero", 64'(div_by_zero), 64'(edz));
    check("in_ready_busy", 64'(in_ready), 64'd0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("drain_out_valid", 64'(out_valid), 64'd0);
    check("drain_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    p         = '0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_q", 64'(q), 64'd0);
    check("rst_r", 64'(r), 64'd0);
    check("rst_d", 64'(d), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Basic case followed by a 5-cycle consumer stall with in_valid held high
    run_req(20'd600, 10'd5, 10'd20, 1'b0);
    in_valid = 1'b1;
    p        = 20'd12345;
    a        = 10'd1;
    b        = 10'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_q", 64'(q), 64'd30);
      check("stall_r", 64'(r), 64'd0);
      check("stall_d", 64'(d), 64'd35);
      check("stall_dz", 64'(div_by_zero), 64'd0);
    end
    in_valid = 1'b0;
    drain();
    @(negedge clk);
    check("no_second_accept", 64'(out_valid), 64'd0);

    run_req(20'd1046529, 10'd1023, 10'd1023, 1'b0);
    drain();
    run_req(20'd1000, 10'd0, 10'd7, 1'b0);
    drain();
    run_req(20'd77, 10'd9, 10'd0, 1'b0);
    drain();

    // Reset in the middle of a division
    p        = 20'd1000;
    a        = 10'd0;
    b        = 10'd7;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    #1;
    check("after_rst_in_ready", 64'(in_ready), 64'd1);
    check("after_rst_out_valid", 64'(out_valid), 64'd0);
    check("after_rst_q", 64'(q), 64'd0);
    @(negedge clk);
    run_req(20'd1000, 10'd3, 10'd7, 1'b0);
    drain();

    // Randomized requests with handshake noise while busy
    for (int n = 0; n < 16; n++) begin
      logic [W-1:0] rb;
      rb = ($urandom_range(0, 5) == 0) ? W'(0) : W'($urandom);
      run_req((2*W)'($urandom), W'($urandom), rb, 1'b1);
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/presub_recover_unsigned.md
PRESUB_RECOVER_UNSIGNED -- requirements
Module: presub_recover_unsigned

Interface
REQ-001 Parameter: WIDTH, default 10, operand width W; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  request valid.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: p  input  2W  unsigned product, nominally (d - a) * b.
REQ-007 Port: a  input  W  unsigned subtrahend to re-add.
REQ-008 Port: b  input  W  unsigned divisor.
REQ-009 Port: out_valid  output  1  result valid.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: q  output  2W  quotient p / b.
REQ-012 Port: r  output  W  remainder p % b.
REQ-013 Port: d  output  W  recovered operand, (a + q[W-1:0]) mod 2^W.
REQ-014 Port: div_by_zero  output  1  set when the accepted b was 0.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE with rst low.
REQ-017 Accept SHALL occur in cycle T when in_valid && in_ready; p, a, b are latched in T and later input changes are ignored.
REQ-018 On accept with b != 0: IDLE -> RUN; restoring division, one quotient bit per cycle, MSB first, 2W iterations in cycles T+1..T+2W.
REQ-019 After the last iteration: RUN -> DONE; out_valid SHALL be 1 from cycle T+2W+1 (latency 2W+1, i.e. 21 at W=10).
REQ-020 On accept with b == 0: IDLE -> DONE directly; out_valid from T+1; q = all ones, r = p[W-1:0], d = (a - 1) mod 2^W, div_by_zero = 1.
REQ-021 Remainder register SHALL be W+1 bits internally so the compare/subtract never overflows; r output is its low W bits (r < b guaranteed).
REQ-022 In DONE, q, r, d, div_by_zero and out_valid SHALL hold stable until out_valid && out_ready.
REQ-023 On output handshake: DONE -> IDLE; in_ready rises the following cycle (no same-cycle accept-on-drain).
REQ-024 out_ready asserted outside DONE SHALL have no effect.
REQ-025 in_valid asserted outside IDLE SHALL have no effect and SHALL NOT be queued.
REQ-026 div_by_zero SHALL be 0 for every result with b != 0.
REQ-027 Outputs q, r, d, div_by_zero SHALL be registered; none combinational from inputs.

Reset
REQ-028 rst high in any state SHALL force IDLE at the next edge, abandoning any in-flight division.
REQ-029 Reset values: out_valid 0, q 0, r 0, d 0, div_by_zero 0; in_ready 0 while rst high, 1 in the first cycle after rst falls.
REQ-030 rst asserted in the same cycle as an accept or output handshake SHALL take priority.

Structure
REQ-031 Shared package presub_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default-width constant PRESUB_WIDTH = 10.
REQ-032 One sub-module, presub_div_step: combinational single restoring iteration (shift, compare, conditional subtract, quotient bit out), instantiated once.
REQ-033 Iteration counter SHALL be clog2(2W)+1 bits wide; no multipliers are inferred.

Verification
REQ-034 W=10, p=600, a=5, b=20 -> at T+21: q=30, r=0, d=35, div_by_zero=0.
REQ-035 p=1046529, a=1023, b=1023 -> q=1023, r=0, d=1022 (wrap-around).
REQ-036 p=1000, a=0, b=7 -> q=142, r=6, d=142.
REQ-037 p=77, a=9, b=0 -> at T+1: q=0xFFFFF, r=77, d=8, div_by_zero=1.
REQ-038 Result ready, out_ready held low 5 cycles, in_valid high throughout -> outputs stable, in_ready 0, no second accept; handshake on cycle 6 -> in_ready 1 next cycle.
REQ-039 rst pulsed at iteration 7 of a division -> out_valid 0, in_ready 1 the cycle after rst falls, next request yields correct result.
